// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds the write-source enum, the default bus widths and the buffered unit-result entry.
// No logic lives here.
package wb_arb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_UNIT = 2'd2
  } rf_src_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_unit_fifo.sv
// Circular buffer of long-latency unit results awaiting a free write-port slot.
// The head entry is readable in the cycle after its push; there is no fall-through path.
// The caller must not push when full_o is high or pop when empty_o is high; ent_vld_o and ent_addr_o expose every slot for address matching.
module wb_unit_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  wb_entry_t            din_i,
  input  logic                 pop_i,
  output wb_entry_t            head_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH-1:0]     ent_vld_o,
  output logic [WB_ADDR_W-1:0] ent_addr_o [DEPTH]
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Next pointers, occupancy and per-slot valid bits; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push_i) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
    end
  end

  // Entry storage; cleared on reset so the scoreboard never compares against stale addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Per-slot address taps for the pending-write compare.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr_o[i] = mem_q[i].addr;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;
  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign ent_vld_o = vld_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline writeback has priority, unit results are buffered and drained in idle slots.
// Latency is one cycle from the grant decision to rf_*; a unit result needs at least two cycles from push to rf_*.
// u_ready_o drops when the buffer is full; a head denied for MAX_WAIT cycles raises stall_req_o until it drains.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_regwrite_i,
  input  logic              p_memtoreg_i,
  input  logic [DATA_W-1:0] p_alu_result_i,
  input  logic [DATA_W-1:0] p_read_data_i,
  input  logic [ADDR_W-1:0] p_write_addr_i,
  input  logic              u_valid_i,
  output logic              u_ready_o,
  input  logic [ADDR_W-1:0] u_addr_i,
  input  logic [DATA_W-1:0] u_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [1:0]        rf_src_o,
  output logic              stall_req_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rs_pend_o,
  output logic              rt_pend_o,
  output logic              rd_pend_o,
  output logic [CNT_W-1:0]  fifo_count_o
);

  // The buffered entry type takes its widths from the package, so DATA_W/ADDR_W track those defaults.
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  wb_entry_t             push_ent;
  wb_entry_t             head;
  logic                  fifo_full, fifo_empty;
  logic                  push_acc, push_fifo, pop_head, pipe_req;
  logic [DATA_W-1:0]     pipe_data;
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [ADDR_W-1:0]     ent_addr [FIFO_DEPTH];

  logic                  rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  rf_src_t               rf_src_q, rf_src_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  stall_q, stall_d;
  logic                  rs_hit, rt_hit, rd_hit;

  // Ready depends only on registered occupancy, so it never combinationally follows u_valid_i.
  assign u_ready_o = !fifo_full;
  assign push_acc  = u_valid_i && u_ready_o;
  // Results aimed at r0 are handshaken normally but never occupy a slot.
  assign push_fifo = push_acc && (u_addr_i != '0);
  assign push_ent  = '{addr: u_addr_i, data: u_data_i};

  // A pipeline write to r0 is no request at all, which frees the slot for the unit.
  assign pipe_req  = p_regwrite_i && (p_write_addr_i != '0);
  assign pipe_data = p_memtoreg_i ? p_read_data_i : p_alu_result_i;
  assign pop_head  = !pipe_req && !fifo_empty;

  wb_unit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_fifo),
    .din_i      (push_ent),
    .pop_i      (pop_head),
    .head_o     (head),
    .count_o    (fifo_count_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .ent_vld_o  (ent_vld),
    .ent_addr_o (ent_addr)
  );

  // Grant selection for the next rf_* value; idle slots present all-zero address and data.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    rf_src_d   = SRC_NONE;
    if (pipe_req) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = p_write_addr_i;
      rf_wdata_d = pipe_data;
      rf_src_d   = SRC_PIPE;
    end else if (pop_head) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
      rf_src_d   = SRC_UNIT;
    end
  end

  // Head age counts denied cycles and saturates; stall follows the saturated age one cycle later.
  always_comb begin
    age_d   = age_q;
    stall_d = (age_q == AGE_MAX);
    if (fifo_empty || pop_head) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 1'b1;
    end
  end

  // Write-port output registers, age counter and stall request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= SRC_NONE;
      age_q      <= '0;
      stall_q    <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_src_q   <= rf_src_d;
      age_q      <= age_d;
      stall_q    <= stall_d;
    end
  end

  // Pending-write scoreboard: any buffered unit entry, or a unit write sitting in the rf_* stage.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rd_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == rs_addr_i)) rs_hit = 1'b1;
      if (ent_vld[i] && (ent_addr[i] == rt_addr_i)) rt_hit = 1'b1;
      if (ent_vld[i] && (ent_addr[i] == rd_addr_i)) rd_hit = 1'b1;
    end
    if (rf_we_q && (rf_src_q == SRC_UNIT)) begin
      if (rf_waddr_q == rs_addr_i) rs_hit = 1'b1;
      if (rf_waddr_q == rt_addr_i) rt_hit = 1'b1;
      if (rf_waddr_q == rd_addr_i) rd_hit = 1'b1;
    end
    rs_pend_o = rs_hit && (rs_addr_i != '0);
    rt_pend_o = rt_hit && (rt_addr_i != '0);
    rd_pend_o = rd_hit && (rd_addr_i != '0);
  end

  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign rf_src_o    = rf_src_q;
  assign stall_req_o = stall_q;

endmodule
